// File: rtl/axi_lite_mem_slave_if.sv
// AXI-lite bus bundle for axi_lite_mem_slave: AW/W/B write channels and AR/R read channels.
// The master modport drives requests, the slave modport answers them.
interface axi_lite_mem_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_W-1:0]     aw_addr;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_W-1:0]     ar_addr;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_W-1:0]     r_data;
    logic [1:0]            r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI-lite word-addressed memory slave with byte strobes and independent read/write paths.
// Define AXI_SLV_ERR_EN to answer out-of-range indices with SLVERR instead of wrapping modulo DEPTH.
module axi_lite_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_lite_mem_slave_if.slave   bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rState_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              awHeld_q, awHeld_d;
    logic [IDX_W-1:0]  awWord_q, awWord_d;
    logic              wHeld_q,  wHeld_d;
    logic [DATA_W-1:0] wData_q,  wData_d;
    logic [STRB_W-1:0] wStrb_q,  wStrb_d;
    logic              bValid_q, bValid_d;
    logic [1:0]        bResp_q,  bResp_d;

    rState_t           rState_q, rState_d;
    logic [DATA_W-1:0] rData_q,  rData_d;
    logic [1:0]        rResp_q,  rResp_d;

    logic              awReady, wReady, arReady, rValid;
    logic              commit;
    logic [IDX_W-1:0]  arWord;
    logic [MEM_AW-1:0] awIdx, arIdx;
    logic              awInRange, arInRange;
    logic              unusedAddrBits;

    // Wrapping keeps every array access legal even when the error feature reports the index as bad.
    function automatic logic [MEM_AW-1:0] wrapIndex(input logic [IDX_W-1:0] word);
        return MEM_AW'(32'(word) % 32'(DEPTH));
    endfunction

    assign arWord = bus.ar_addr[ADDR_W-1:OFF_W];
    assign awIdx  = wrapIndex(awWord_q);
    assign arIdx  = wrapIndex(arWord);
    assign commit = awHeld_q && wHeld_q;

    assign unusedAddrBits = ^{bus.aw_addr[OFF_W-1:0], bus.ar_addr[OFF_W-1:0]};

`ifdef AXI_SLV_ERR_EN
    assign awInRange = 32'(awWord_q) < 32'(DEPTH);
    assign arInRange = 32'(arWord)   < 32'(DEPTH);
`else
    assign awInRange = 1'b1;
    assign arInRange = 1'b1;
`endif

    // Write path: AW and W are parked independently, committed together one cycle after both are held.
    always_comb begin
        awHeld_d = awHeld_q;
        awWord_d = awWord_q;
        wHeld_d  = wHeld_q;
        wData_d  = wData_q;
        wStrb_d  = wStrb_q;
        bValid_d = bValid_q;
        bResp_d  = bResp_q;
        awReady  = !awHeld_q && !bValid_q;
        wReady   = !wHeld_q && !bValid_q;

        if (bus.aw_valid && awReady) begin
            awHeld_d = 1'b1;
            awWord_d = bus.aw_addr[ADDR_W-1:OFF_W];
        end
        if (bus.w_valid && wReady) begin
            wHeld_d = 1'b1;
            wData_d = bus.w_data;
            wStrb_d = bus.w_strb;
        end
        if (commit) begin
            awHeld_d = 1'b0;
            wHeld_d  = 1'b0;
            bValid_d = 1'b1;
            bResp_d  = awInRange ? RESP_OKAY : RESP_SLVERR;
        end
        if (bValid_q && bus.b_ready) begin
            bValid_d = 1'b0;
        end
    end

    // Read path: the array is sampled at the AR handshake, so a same-edge commit is not yet visible.
    always_comb begin
        rState_d = rState_q;
        rData_d  = rData_q;
        rResp_d  = rResp_q;
        arReady  = 1'b0;
        rValid   = 1'b0;

        case (rState_q)
            R_IDLE: begin
                arReady = 1'b1;
                if (bus.ar_valid) begin
                    rState_d = R_RESP;
                    rData_d  = arInRange ? mem[arIdx] : '0;
                    rResp_d  = arInRange ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_RESP: begin
                rValid = 1'b1;
                if (bus.r_ready) begin
                    rState_d = R_IDLE;
                end
            end
            default: begin
                rState_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awHeld_q <= 1'b0;
            awWord_q <= '0;
            wHeld_q  <= 1'b0;
            wData_q  <= '0;
            wStrb_q  <= '0;
            bValid_q <= 1'b0;
            bResp_q  <= RESP_OKAY;
            rState_q <= R_IDLE;
            rData_q  <= '0;
            rResp_q  <= RESP_OKAY;
        end else begin
            awHeld_q <= awHeld_d;
            awWord_q <= awWord_d;
            wHeld_q  <= wHeld_d;
            wData_q  <= wData_d;
            wStrb_q  <= wStrb_d;
            bValid_q <= bValid_d;
            bResp_q  <= bResp_d;
            rState_q <= rState_d;
            rData_q  <= rData_d;
            rResp_q  <= rResp_d;
        end
    end

    // Array contents survive reset; an asynchronous reset clears the holds so no partial commit happens.
    always_ff @(posedge clk) begin
        if (commit && awInRange) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wStrb_q[i]) begin
                    mem[awIdx][8*i +: 8] <= wData_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.aw_ready = awReady;
    assign bus.w_ready  = wReady;
    assign bus.b_valid  = bValid_q;
    assign bus.b_resp   = bResp_q;
    assign bus.ar_ready = arReady;
    assign bus.r_valid  = rValid;
    assign bus.r_data   = rData_q;
    assign bus.r_resp   = rResp_q;

endmodule
